// File: rtl/pc_ir_unit.sv
// pc_ir_unit: multicycle datapath front end.
// Holds PC, IR, MDR and ALUOut, counts IR loads, and latches a sticky flag
// whenever a PC write targets a non-word-aligned address.
module pc_ir_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             PCWrite,
    input  logic             Branch,
    input  logic [1:0]       PCSrc,
    input  logic             IRWrite,
    input  logic             Zero,
    input  logic [31:0]      ALUResult,
    input  logic [31:0]      MemRdData,
    output logic [31:0]      PC,
    output logic [31:0]      Instr,
    output logic [5:0]       Opcode,
    output logic [31:0]      Data,
    output logic [31:0]      ALUOut,
    output logic [CNT_W-1:0] FetchCount,
    output logic             PCMisaligned
);

    localparam logic [1:0]       SRC_ALU     = 2'b00;
    localparam logic [1:0]       SRC_ALUOUT  = 2'b01;
    localparam logic [1:0]       SRC_JUMP    = 2'b10;
    localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [31:0]      r_pc;
    logic [31:0]      r_instr;
    logic [31:0]      r_mdr;
    logic [31:0]      r_aluout;
    logic [CNT_W-1:0] r_fetch_count;
    logic             r_misaligned;

    logic             w_pc_en;
    logic             w_src_valid;
    logic             w_pc_load;
    logic             w_target_misaligned;
    logic [31:0]      w_target;

    // Branch only writes the PC when the ALU reports equality; PCWrite dominates.
    assign w_pc_en             = PCWrite | (Branch & Zero);
    assign w_src_valid         = (PCSrc != 2'b11);
    assign w_pc_load           = w_pc_en & w_src_valid;
    assign w_target_misaligned = w_pc_load & (w_target[1:0] != 2'b00);

    // Next-PC mux; the jump target uses the pre-edge PC and IR.
    always_comb begin
        w_target = r_pc;
        case (PCSrc)
            SRC_ALU:    w_target = ALUResult;
            SRC_ALUOUT: w_target = r_aluout;
            SRC_JUMP:   w_target = {r_pc[31:28], r_instr[25:0], 2'b00};
            default:    w_target = r_pc;
        endcase
    end

    // PC register; low bits are forced to zero so the PC is always word aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else if (w_pc_load) begin
            r_pc <= {w_target[31:2], 2'b00};
        end
    end

    // Sticky misalignment flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_misaligned <= 1'b0;
        end else if (w_target_misaligned) begin
            r_misaligned <= 1'b1;
        end
    end

    // Instruction register and fetch counter advance together on IRWrite.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr       <= 32'h0;
            r_fetch_count <= '0;
        end else if (IRWrite) begin
            r_instr       <= MemRdData;
            r_fetch_count <= r_fetch_count + CNT_ONE;
        end
    end

    // MDR and ALUOut capture every cycle with no enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mdr    <= 32'h0;
            r_aluout <= 32'h0;
        end else begin
            r_mdr    <= MemRdData;
            r_aluout <= ALUResult;
        end
    end

    assign PC           = r_pc;
    assign Instr        = r_instr;
    assign Opcode       = r_instr[31:26];
    assign Data         = r_mdr;
    assign ALUOut       = r_aluout;
    assign FetchCount   = r_fetch_count;
    assign PCMisaligned = r_misaligned;

endmodule

// File: doc/pc_ir_unit.md
Name: pc_ir_unit

Overview:
- Sequential datapath front end that sits directly downstream of the multicycle main controller.
- Consumes the controller's PCWrite, Branch, PCSrc and IRWrite, plus the ALU Zero/result and the memory read data.
- Holds the architectural PC, Instruction Register (IR), Memory Data Register (MDR) and ALUOut register.
- Drives the Opcode back to the controller, and exposes a retired-fetch counter and a sticky misalignment flag.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 00.
- CNT_W, 16, width of the fetch counter.

Ports:
- clk  input  1  system clock; all registers update on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- PCWrite  input  1  unconditional PC write enable from the controller.
- Branch  input  1  conditional PC write enable (beq), qualified by Zero.
- PCSrc  input  2  next-PC select from the controller.
- IRWrite  input  1  IR load enable.
- Zero  input  1  ALU zero flag from the current cycle.
- ALUResult  input  32  combinational ALU output from the current cycle.
- MemRdData  input  32  memory read data.
- PC  output  32  current PC register.
- Instr  output  32  IR contents.
- Opcode  output  6  Instr[31:26], sent to the controller.
- Data  output  32  MDR contents.
- ALUOut  output  32  registered ALUResult.
- FetchCount  output  CNT_W  number of IR loads since reset.
- PCMisaligned  output  1  sticky flag: a PC write attempted a non-word-aligned target.

Behaviour:
- Reset (asynchronous, any time, including mid-instruction): PC=RESET_PC; Instr, Data, ALUOut and FetchCount are 0; PCMisaligned=0; Opcode therefore reads 6'b000000.
- PC enable: PCEn = PCWrite | (Branch & Zero).
- Next-PC select, evaluated in the same cycle as PCEn:
  - 00: ALUResult (PC+4 during fetch).
  - 01: ALUOut (branch target computed in decode).
  - 10: jump target {PC[31:28], Instr[25:0], 2'b00}, formed from the current (pre-edge) PC and Instr.
  - 11: reserved; PC holds even when PCEn=1, and no flag is set.
- Alignment: if PCEn=1, PCSrc≠11 and the selected target has bits[1:0]≠00:
  - PC loads the target with bits[1:0] forced to 00;
  - PCMisaligned sets to 1 and stays 1 until reset.
- IR: loads MemRdData on an edge where IRWrite=1, otherwise holds. FetchCount increments by 1 on the same edge and wraps from all-ones to 0.
- MDR (Data): loads MemRdData on every edge; no enable.
- ALUOut: loads ALUResult on every edge; no enable.
- Simultaneous events:
  - IRWrite and PCWrite on the same edge (fetch): IR captures data for the old PC, and PC takes the new value. There is no ordering hazard because both are registered.
  - IRWrite=1 with PCSrc=10 on the same edge: the jump target uses the old Instr.
  - PCWrite=1 and Branch=1 with Zero=0: PC still updates, because PCWrite dominates.
- Latency: every output is registered and reflects its inputs one edge later. Opcode is a combinational slice of Instr only.
- No combinational path runs from any input to any output.

Test Plan:
- Reset release, then fetch cycle: PCWrite=1, IRWrite=1, PCSrc=00, ALUResult=32'h4, MemRdData=32'h8C08_0010 -> after one edge: PC=4, Instr=32'h8C08_0010, Opcode=6'b100011, FetchCount=1.
- Branch taken vs not taken: ALUOut preloaded 32'h40; Branch=1, PCSrc=01.
  - Zero=1 -> PC=32'h40.
  - Zero=0 -> PC unchanged.
- Jump: PC=32'h1000_0008, Instr=32'h0800_0100, PCSrc=10, PCWrite=1 -> PC=32'h1000_0400. Repeat with IRWrite=1 in the same cycle and a different MemRdData -> PC still 32'h1000_0400.
- Misaligned target: PCWrite=1, PCSrc=00, ALUResult=32'h0000_0013 -> PC=32'h0000_0010, PCMisaligned=1. Later aligned writes leave PCMisaligned=1.
- Reserved select: PCSrc=11, PCWrite=1 -> PC holds and PCMisaligned is unchanged. Counter wrap: CNT_W=4 with 16 IRWrite pulses -> FetchCount returns to 0.
- Asynchronous reset asserted mid-cycle, between edges, while in a multi-cycle sequence -> all outputs take their reset values immediately, without waiting for clk. Deasserting reset -> the first edge behaves as a fresh fetch from RESET_PC.
